apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master.sv | 116 +++++++++++
 tb/tb_apb_cmd_master.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: converts a valid/ready command into one APB transfer
// (SETUP -> ACCESS with PREADY wait states) and returns a held response.
// An optional wait-state timeout aborts a transfer the completer never ends.
module apb_cmd_master #(
    parameter int AW      = 12,
    parameter int TIMEOUT = 255
) (
    input  logic          pclk,
    input  logic          resetn,
    // command side
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_write,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_strb,
    input  logic [2:0]    req_prot,
    // response side
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    // APB requester
    output logic [AW-1:0] PADDR,
    output logic          PWRITE,
    output logic [3:0]    PSTRB,
    output logic [2:0]    PPROT,
    output logic [31:0]   PWDATA,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          APBACTIVE,
    input  logic [31:0]   PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    // Counter just wide enough to reach TIMEOUT; with the timeout disabled it
    // is a full 32-bit saturating counter so it never wraps.
    localparam int CW = (TIMEOUT == 0) ? 32 :
                        (TIMEOUT == 1) ? 1  : $clog2(longint'(TIMEOUT) + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          timeout_hit;

    // PREADY wins over the timeout when both land on the same cycle
    assign timeout_hit = (TIMEOUT != 0) && (state == S_ACCESS) && !PREADY && (cnt == TO_VAL);

    // Handshake/APB controls decode straight from the state register, so an
    // async reset drops PSEL/PENABLE without waiting for a clock.
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign PSEL      = (state == S_SETUP) || (state == S_ACCESS);
    assign PENABLE   = (state == S_ACCESS);
    assign APBACTIVE = PSEL;

    // State register
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (req_valid) nxt = S_SETUP;
            S_SETUP:  nxt = S_ACCESS;
            S_ACCESS: if (PREADY || timeout_hit) nxt = S_RESP;
            S_RESP:   if (rsp_ready) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // Request capture, wait counter and response capture
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PSTRB       <= '0;
            PPROT       <= '0;
            PWDATA      <= '0;
            cnt         <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                PADDR  <= req_addr;
                PWRITE <= req_write;
                PSTRB  <= req_strb;
                PPROT  <= req_prot;
                PWDATA <= req_wdata;
                cnt    <= '0;
            end
            if (state == S_ACCESS) begin
                if (PREADY) begin
                    rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                    rsp_err     <= PSLVERR;
                    rsp_timeout <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_rdata   <= 32'h0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end else if (cnt != '1) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master (TIMEOUT=4): zero-wait read, waited write,
// slave error, timeout and its PREADY-priority variant, response backpressure,
// and reset during ACCESS.
module tb_apb_cmd_master;

    localparam int AW = 12;

    logic          pclk, resetn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] PADDR;
    logic          PWRITE, PSEL, PENABLE, APBACTIVE, PREADY, PSLVERR;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [31:0]   PWDATA, PRDATA;

    int n_tests = 0;
    int n_fail  = 0;

    apb_cmd_master #(.AW(AW), .TIMEOUT(4)) dut (
        .pclk(pclk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSTRB(PSTRB), .PPROT(PPROT),
        .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .APBACTIVE(APBACTIVE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One command through to rsp_valid. nwait<0 means PREADY never rises.
    // Checks field stability on every PSEL cycle and returns cycle counts.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int nwait,
                        input logic [31:0] rd, input bit err,
                        output int n_acc, output int n_psel);
        bit seen;
        @(negedge pclk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd;
        req_strb = st; req_prot = pr; PREADY = 0; PSLVERR = 0; PRDATA = 32'h0BAD_0BAD;
        @(posedge pclk); #1;
        // scramble the command bus to prove the fields were registered
        req_valid = 0; req_write = ~wr; req_addr = ~a; req_wdata = ~wd;
        req_strb = ~st; req_prot = ~pr;
        n_acc = 0; n_psel = 0; seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge pclk);
            if (rsp_valid) begin seen = 1; break; end
            check("psel_active", PSEL, 1);
            check("apbactive", APBACTIVE, PSEL);
            check("paddr_stable", PADDR, a);
            check("pwrite_stable", PWRITE, wr);
            check("pstrb_stable", PSTRB, st);
            check("pprot_stable", PPROT, pr);
            check("pwdata_stable", PWDATA, wd);
            n_psel++;
            if (n_psel == 1) check("penable_setup", PENABLE, 0);
            if (PENABLE) begin
                n_acc++;
                PREADY = (nwait >= 0) && (n_acc > nwait);
                PRDATA = rd; PSLVERR = err;
            end
        end
        check("rsp_seen", seen, 1);
        check("psel_in_resp", PSEL, 0);
        check("penable_in_resp", PENABLE, 0);
        PREADY = 0; PSLVERR = 0; PRDATA = 32'h0;
    endtask

    // Hold off rsp_ready, verify a stable response, then consume it.
    task automatic ack(input int hold, input logic [31:0] rd, input bit err, input bit to,
                       input logic [AW-1:0] a);
        for (int i = 0; i < hold; i++) begin
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_req_ready", req_ready, 0);
            check("hold_rdata", rsp_rdata, rd);
            check("hold_err", rsp_err, err);
            @(negedge pclk);
        end
        check("rsp_rdata", rsp_rdata, rd);
        check("rsp_err", rsp_err, err);
        check("rsp_timeout", rsp_timeout, to);
        rsp_ready = 1;
        @(posedge pclk); #1 rsp_ready = 0;
        @(negedge pclk);
        check("rsp_valid_after_ack", rsp_valid, 0);
        check("req_ready_after_ack", req_ready, 1);
        check("paddr_hold_idle", PADDR, a);
    endtask

    initial begin
        int na, np;
        resetn = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0; rsp_ready = 0; PRDATA = '0; PREADY = 0; PSLVERR = 0;
        repeat (2) @(posedge pclk);
        #1;
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_apbactive", APBACTIVE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        @(negedge pclk) resetn = 1;

        // zero-wait read: PSEL at N+1, PENABLE at N+2, rsp_valid at N+3
        xfer(0, 12'h010, 32'h0, 4'h0, 3'h2, 0, 32'hDEAD_BEEF, 0, na, np);
        check("rd_acc_cycles", na, 1);
        check("rd_psel_cycles", np, 2);
        ack(0, 32'hDEAD_BEEF, 0, 0, 12'h010);

        // write with three wait states: five PSEL cycles, rdata forced to 0
        xfer(1, 12'h123, 32'hA5A5_A5A5, 4'h3, 3'h1, 3, 32'h1234_5678, 0, na, np);
        check("wr_acc_cycles", na, 4);
        check("wr_psel_cycles", np, 5);
        ack(0, 32'h0, 0, 0, 12'h123);

        // read completing with PSLVERR
        xfer(0, 12'h0F0, 32'h0, 4'h0, 3'h0, 1, 32'hCAFE_F00D, 1, na, np);
        check("err_acc_cycles", na, 2);
        ack(0, 32'hCAFE_F00D, 1, 0, 12'h0F0);

        // timeout: PREADY never comes, abort after 5 ACCESS cycles
        xfer(0, 12'h200, 32'h0, 4'h0, 3'h0, -1, 32'h5555_AAAA, 0, na, np);
        check("to_acc_cycles", na, 5);
        ack(0, 32'h0, 1, 1, 12'h200);

        // PREADY on the 5th ACCESS cycle beats the timeout and clears rsp_timeout
        xfer(0, 12'h204, 32'h0, 4'h0, 3'h0, 4, 32'h7777_0001, 0, na, np);
        check("to_edge_acc_cycles", na, 5);
        ack(0, 32'h7777_0001, 0, 0, 12'h204);

        // backpressure: rsp_ready low for 10 cycles
        xfer(0, 12'h3FC, 32'h0, 4'h0, 3'h4, 0, 32'h0102_0304, 0, na, np);
        ack(10, 32'h0102_0304, 0, 0, 12'h3FC);

        // reset during ACCESS drops PSEL at once and produces no response
        @(negedge pclk);
        req_valid = 1; req_write = 0; req_addr = 12'h040; PREADY = 0;
        @(posedge pclk); #1 req_valid = 0;
        @(negedge pclk);
        @(negedge pclk);
        check("rst_mid_penable_before", PENABLE, 1);
        #2 resetn = 0;
        #1;
        check("rst_mid_psel", PSEL, 0);
        check("rst_mid_penable", PENABLE, 0);
        check("rst_mid_apbactive", APBACTIVE, 0);
        @(negedge pclk) resetn = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("rst_mid_no_rsp", rsp_valid, 0);
            check("rst_mid_req_ready", req_ready, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
